// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: PC select encodings,
// reset/bubble constants, fetch FSM states and an immediate sign-extender.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b10;
    localparam logic [1:0] PC_J   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/if_stage_npc_sel.sv
// Next-PC selector: computes PC+4, the branch target and the jump target
// of the ID-stage instruction, and picks one according to Pcsrc.
// Pcsrc 01 is not a real encoding and falls back to sequential.
module npc_sel (
    input  logic [31:0] pc,
    input  logic [31:0] idpc4,
    input  logic [31:0] inst,
    input  logic [1:0]  pcsrc,
    output logic [31:0] pc4,
    output logic [31:0] npc
);
    import if_stage_pkg::*;

    logic [31:0] offset;
    logic [31:0] brtarget;
    logic [31:0] jtarget;

    assign pc4      = pc + 32'd4;
    assign offset   = sext16(inst[15:0]) << 2;
    assign brtarget = idpc4 + offset;
    assign jtarget  = {idpc4[31:28], inst[25:0], 2'b00};

    // Select the next PC; anything other than branch or jump is sequential
    always_comb begin
        npc = pc4;
        case (pcsrc)
            PC_BR:   npc = brtarget;
            PC_J:    npc = jtarget;
            default: npc = pc4;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Owns the PC, issues word fetches over an Ireq/Irdy handshake and presents
// the decoded fields of the ID instruction to the control unit.
// Optional macro IF_DELAY_SLOT_EN: keep the word fetched in the redirect
// cycle as a valid branch delay slot instead of squashing it.
module if_stage (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic [1:0]  Pcsrc,
    input  logic        STALL,
    output logic        Ireq,
    output logic [31:0] Iaddr,
    input  logic        Irdy,
    input  logic [31:0] Idata,
    output logic [31:0] Inst,
    output logic [31:0] IdPc4,
    output logic        IdValid,
    output logic [5:0]  Op,
    output logic [5:0]  Func,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [15:0] Imm
);
    import if_stage_pkg::*;

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  pc4;
    logic [31:0]  npc;
    logic         redirect;

    npc_sel u_npc_sel (
        .pc    (pc),
        .idpc4 (IdPc4),
        .inst  (Inst),
        .pcsrc (Pcsrc),
        .pc4   (pc4),
        .npc   (npc)
    );

    // Only a non-stalled branch/jump from the ID instruction steers the PC
    assign redirect = !STALL && Pcsrc[1];

    assign Op   = Inst[31:26];
    assign Rs   = Inst[25:21];
    assign Rt   = Inst[20:16];
    assign Rd   = Inst[15:11];
    assign Imm  = Inst[15:0];
    assign Func = Inst[5:0];

    // Fetch FSM; Iaddr is its own register so it stays on the stale address in DROP
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            Iaddr   <= RESET_PC;
            Ireq    <= 1'b0;
            Inst    <= NOP_WORD;
            IdPc4   <= 32'h0000_0000;
            IdValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    Ireq  <= 1'b1;
                    Iaddr <= pc;
                end
                REQ: begin
                    if (!STALL) begin
                        if (Irdy) begin
                            if (redirect) begin
                                pc    <= npc;
                                Iaddr <= npc;
`ifdef IF_DELAY_SLOT_EN
                                Inst    <= Idata;
                                IdPc4   <= pc4;
                                IdValid <= 1'b1;
`else
                                Inst    <= NOP_WORD;
                                IdValid <= 1'b0;
`endif
                            end else begin
                                Inst    <= Idata;
                                IdPc4   <= pc4;
                                IdValid <= 1'b1;
                                pc      <= pc4;
                                Iaddr   <= pc4;
                            end
                        end else begin
                            Inst    <= NOP_WORD;
                            IdValid <= 1'b0;
                            if (redirect) begin
                                pc    <= npc;
                                state <= DROP;
                            end
                        end
                    end
                end
                DROP: begin
                    if (!STALL) begin
                        Inst    <= NOP_WORD;
                        IdValid <= 1'b0;
                        if (redirect) begin
                            pc <= npc;
                        end
                        if (Irdy) begin
                            state <= REQ;
                            Iaddr <= redirect ? npc : pc;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    Ireq  <= 1'b0;
                end
            endcase
        end
    end

endmodule
